// File: rtl/latealu_pkg.sv
// Shared definitions for the late-ALU stage: op codes, exception codes,
// the mult/div sequencer states and op-class helpers.
package latealu_pkg;

    localparam logic [5:0] OP_SLL   = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MULTU = 6'b000101;
    localparam logic [5:0] OP_DIV   = 6'b000110;
    localparam logic [5:0] OP_DIVU  = 6'b000111;
    localparam logic [5:0] OP_MFHI  = 6'b001000;
    localparam logic [5:0] OP_MFLO  = 6'b001001;
    localparam logic [5:0] OP_MTHI  = 6'b001010;
    localparam logic [5:0] OP_MTLO  = 6'b001011;

    localparam logic [2:0] EXC_NONE   = 3'b000;
    localparam logic [2:0] EXC_BAD_OP = 3'b001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Ops that read or write HI/LO; these must wait for the iterative unit.
    function automatic logic is_hilo_op(input logic [5:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

    function automatic logic is_muldiv_op(input logic [5:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/pipeline_muldiv.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, one bit per
// cycle; signs and divide-by-zero are resolved combinationally in FIX, where done_o pulses.
module pipeline_muldiv
    import latealu_pkg::*;
#(
    parameter int MULDIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);

    localparam int               CNT_W     = $clog2(MULDIV_STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULDIV_STEPS - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             signed_q, signed_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             b_zero_q, b_zero_d;
    logic [31:0]      a_orig_q, a_orig_d;
    logic [31:0]      mag_a_q, mag_a_d;
    logic [31:0]      mag_b_q, mag_b_d;
    logic [31:0]      acc_hi_q, acc_hi_d;
    logic [31:0]      acc_lo_q, acc_lo_d;

    logic             start_signed;
    logic [31:0]      start_mag_a;
    logic [31:0]      start_mag_b;
    logic [32:0]      mult_sum;
    logic [32:0]      div_rem;
    logic [32:0]      div_diff;
    logic [63:0]      prod;
    logic [63:0]      prod_fix;
    logic [31:0]      quo_fix;
    logic [31:0]      rem_fix;
    logic             neg_result;

    assign start_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign start_mag_a  = (start_signed && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign start_mag_b  = (start_signed && b_i[31]) ? (~b_i + 32'd1) : b_i;

    // Multiply: multiplier sits in acc_lo and shifts out LSB-first while the
    // product grows into acc_hi. Divide: dividend shifts out of acc_lo MSB-first
    // into the partial remainder held in acc_hi; quotient bits fill acc_lo.
    assign mult_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : 33'd0);
    assign div_rem  = {acc_hi_q, acc_lo_q[31]};
    assign div_diff = div_rem - {1'b0, mag_b_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        signed_d = signed_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        a_orig_d = a_orig_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d  = MD_RUN;
                    cnt_d    = '0;
                    is_div_d = (op_i == OP_DIV) || (op_i == OP_DIVU);
                    signed_d = start_signed;
                    neg_a_d  = start_signed && a_i[31];
                    neg_b_d  = start_signed && b_i[31];
                    b_zero_d = (b_i == 32'd0);
                    a_orig_d = a_i;
                    mag_a_d  = start_mag_a;
                    mag_b_d  = start_mag_b;
                    acc_hi_d = 32'd0;
                    acc_lo_d = (op_i == OP_DIV || op_i == OP_DIVU) ? start_mag_a : start_mag_b;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = MD_FIX;
                end
                if (is_div_q) begin
                    if (!div_diff[32]) begin
                        acc_hi_d = div_diff[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = div_rem[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mult_sum[32:1];
                    acc_lo_d = {mult_sum[0], acc_lo_q[31:1]};
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_orig_q <= 32'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            signed_q <= signed_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            a_orig_q <= a_orig_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    // Remainder takes the dividend's sign; quotient and product take the XOR.
    // 0x80000000 / -1 falls out naturally: negating 0x80000000 is a no-op.
    always_comb begin
        prod       = {acc_hi_q, acc_lo_q};
        neg_result = signed_q && (neg_a_q ^ neg_b_q);
        prod_fix   = neg_result ? (~prod + 64'd1) : prod;
        quo_fix    = neg_result ? (~acc_lo_q + 32'd1) : acc_lo_q;
        rem_fix    = (signed_q && neg_a_q) ? (~acc_hi_q + 32'd1) : acc_hi_q;
        if (!is_div_q) begin
            hi_o = prod_fix[63:32];
            lo_o = prod_fix[31:0];
        end else if (b_zero_q) begin
            hi_o = a_orig_q;
            lo_o = 32'hFFFF_FFFF;
        end else begin
            hi_o = rem_fix;
            lo_o = quo_fix;
        end
    end

    assign busy_o = (state_q != MD_IDLE);
    assign done_o = (state_q == MD_FIX);

endmodule

// File: rtl/pipeline_latealu.sv
// Late-ALU stage: one-cycle shifts/pass-through/HI-LO moves, HI/LO owned here and fed by
// a 34-cycle iterative mult/div; stall (combinational) holds upstream on HI/LO ops while busy.
module pipeline_latealu
    import latealu_pkg::*;
#(
    parameter int MULDIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_index_in,
    input  logic [31:0] rd_value_in,
    input  logic [2:0]  exception_in,
    input  logic        latealu_enable,
    input  logic [5:0]  latealu_op,
    input  logic [31:0] latealu_a0,
    input  logic [31:0] latealu_a1,
    output logic        stall,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_value,
    output logic [2:0]  exception,
    output logic        muldiv_busy
);

    logic [4:0]  rd_index_q, rd_index_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic [2:0]  exception_q, exception_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        md_start;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    assign stall    = latealu_enable && is_hilo_op(latealu_op) && md_busy;
    assign md_start = latealu_enable && is_muldiv_op(latealu_op)
                   && (exception_in == EXC_NONE) && !md_busy;

    pipeline_muldiv #(
        .MULDIV_STEPS (MULDIV_STEPS)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .op_i    (latealu_op),
        .a_i     (latealu_a0),
        .b_i     (latealu_a1),
        .busy_o  (md_busy),
        .hi_o    (md_hi),
        .lo_o    (md_lo),
        .done_o  (md_done)
    );

    always_comb begin
        rd_index_d  = rd_index_in;
        rd_value_d  = rd_value_in;
        exception_d = exception_in;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end
        if (stall) begin
            rd_index_d  = 5'd0;
            exception_d = EXC_NONE;
        end else if (exception_in != EXC_NONE) begin
            rd_index_d = 5'd0;
        end else if (latealu_enable) begin
            case (latealu_op)
                OP_SLL:  rd_value_d = latealu_a0 << latealu_a1[4:0];
                OP_SRL:  rd_value_d = latealu_a0 >> latealu_a1[4:0];
                OP_SRA:  rd_value_d = $signed(latealu_a0) >>> latealu_a1[4:0];
                OP_MFHI: rd_value_d = hi_q;
                OP_MFLO: rd_value_d = lo_q;
                OP_MTHI: begin
                    hi_d       = latealu_a0;
                    rd_index_d = 5'd0;
                end
                OP_MTLO: begin
                    lo_d       = latealu_a0;
                    rd_index_d = 5'd0;
                end
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    rd_index_d = 5'd0;
                end
                default: begin
                    exception_d = EXC_BAD_OP;
                    rd_index_d  = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_index_q  <= 5'd0;
            rd_value_q  <= 32'd0;
            exception_q <= EXC_NONE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            rd_index_q  <= rd_index_d;
            rd_value_q  <= rd_value_d;
            exception_q <= exception_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign rd_index    = rd_index_q;
    assign rd_value    = rd_value_q;
    assign exception   = exception_q;
    assign muldiv_busy = md_busy;

endmodule

// File: doc/pipeline_latealu.md
# pipeline_latealu

Late-ALU stage: the consumer of the `latealu_*` bundle that the ALU stage emits, sitting directly after it in the pipeline. It completes shifts in one cycle, passes non-late results through, and owns HI/LO with an iterative 32-step multiply/divide unit. It raises `stall` toward the ALU stage whenever a HI/LO-touching op cannot be accepted.

## Interface
Parameters:
- `MULDIV_STEPS`, default 32: iterations per mult/div; fixed at 32 for correct results, exposed for bench.

Ports (`clk`, `rst`: one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rd_index_in`  in  5  destination index from ALU stage
- `rd_value_in`  in  32  ALU-stage result, used when `latealu_enable=0`
- `exception_in`  in  3  ALU-stage exception code, 0 = none
- `latealu_enable`  in  1  late op valid this cycle
- `latealu_op`  in  6  late op code
- `latealu_a0`  in  32  operand 0: shift source, or mult/div Rs, or mthi/mtlo value
- `latealu_a1`  in  32  operand 1: only [4:0] meaningful for shifts; full width for mult/div
- `stall`  out  1  combinational; upstream holds all inputs while high
- `rd_index`  out  5  registered destination, 0 = no write
- `rd_value`  out  32  registered result
- `exception`  out  3  registered pass-through of `exception_in`
- `muldiv_busy`  out  1  registered; iterative unit active

## Operation
- Op codes: 000001 sll, 000010 srl, 000011 sra, 000100 mult, 000101 multu, 000110 div, 000111 divu, 001000 mfhi, 001001 mflo, 001010 mthi, 001011 mtlo.
- HI/LO class = op codes 000100–001011.
- No late op (`latealu_enable=0`): `rd_index<=rd_index_in`, `rd_value<=rd_value_in`.
- Shifts: `a0` shifted by `a1[4:0]`; sra replicates `a0[31]`.
- mfhi/mflo: `rd_value<=HI/LO`.
- mthi/mtlo: write HI/LO; `rd_index<=0`.
- mult/div: start the sub-unit; `rd_index<=0`.
- `exception_in!=0`: op suppressed (no HI/LO change, no mult/div start); `rd_index<=0`; exception passed through.
- Undefined op code with `latealu_enable=1`: `exception<=3'b001`, `rd_index<=0`.
- `stall = latealu_enable && HI/LO class && muldiv_busy`.
  - While stalled, register a bubble: `rd_index<=0`, `exception<=0`.
  - Shifts and pass-through never stall, even while busy.
- Mult/div states IDLE → RUN (32 steps) → FIX (1 cycle) → IDLE.
  - Operands are taken as magnitudes for signed ops; the sign is fixed in FIX.
  - mult: HI:LO = 64-bit product.
  - div: LO = quotient, HI = remainder; remainder sign follows the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; no exception.
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.

## Timing
- Single-cycle ops: result registered at the edge after the inputs are presented.
- Mult/div accepted at edge E0.
  - `muldiv_busy=1` after E0.
  - RUN steps at E1..E32; FIX at E33 writes HI/LO and clears busy.
  - A HI/LO-class op is accepted no earlier than E34. mfhi presented at E0+1 stalls 33 cycles.
- Reset values: `rd_index=0`, `rd_value=0`, `exception=0`, `muldiv_busy=0`, HI=LO=0, state IDLE.
- Reset mid-operation aborts the op; HI/LO return to 0.
- `rst` has priority over every input.

## Structure
- Shared package `latealu_pkg`: op-code localparams, mult/div state enum, exception codes (none=0, bad op=001).
- One sub-module, `pipeline_muldiv`: iterative shift-add/restoring-divide engine.
  - Inputs: start, op, a, b. Outputs: busy, hi, lo, done pulse.
  - Owns its counter and the sign-fix logic.

## Test plan
- Reset, then sra `a0=0x80000010`, `a1=4` → next cycle `rd_value=0xF8000001`, `rd_index` as given.
- mult `a0=0xFFFFFFFE`, `a1=3`, then mflo, mfhi → `stall` high for 33 cycles; then LO=0xFFFFFFFA, HI=0xFFFFFFFF.
- div `a0=-7`, `a1=2` → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu by 0 of 5 → LO=0xFFFFFFFF, HI=5.
- Start divu, issue sll `a0=1`, `a1=31` during busy → no stall, `rd_value=0x80000000` next cycle.
- Assert `rst` at step 10 of a mult → busy=0 next cycle, mfhi returns 0.
- `exception_in=3'b010` with mthi `a0=0x1234` → `exception=3'b010`, `rd_index=0`; HI unchanged.
